multi_click_stamper: RTL and testbench

Parametrised successor to the four-channel pulse registrar. It timestamps coincident pulses on `N_CHANNELS` detector inputs against a free-running `TIMER_WIDTH` counter, with per-channel masking and optional rising-edge detection. Records are buffered in an internal FIFO and delivered over a valid/ready handshake, so downstream stalls no longer corrupt data. The block sits between the input synchronisers and the record FIFO/USB packer.

---
 rtl/multi_click_stamper.sv | 136 +++++++++++++
 tb/tb_multi_click_stamper.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_click_stamper.sv
// -----------------------------------------------------------------------------
// multi_click_stamper
//
// Timestamps coincident pulses on N_CHANNELS detector inputs against a
// free-running TIMER_WIDTH counter. Each cycle with at least one enabled hit,
// or with the timer at zero while `operate` is set, produces one record.
// Records are queued in an internal FIFO and presented show-ahead on a
// valid/ready interface. Records that find the FIFO full are dropped, and the
// next record that is stored carries a sticky "lost" flag.
//
// Record layout (DATA_W = TIMER_WIDTH + 2 + N_CHANNELS):
//   [TIMER_WIDTH-1:0]         timestamp (timer value before the edge's update)
//   [TIMER_WIDTH]             wrap flag (timer was zero)
//   [TIMER_WIDTH+1]           lost flag (earlier records were dropped)
//   [DATA_W-1:TIMER_WIDTH+2]  channel hit vector
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous, active-high; overrides every other input
//   channel       synchronised detector pulses
//   channel_mask  1 = channel enabled
//   clear         loads zero into the timer at the next edge
//   operate       enables wrap-marker records
//   out_ready     downstream accepts the current record
//   out_valid     `data` holds a record
//   data          record at the FIFO head, zero when empty
//   fifo_level    total number of buffered records
// -----------------------------------------------------------------------------
module multi_click_stamper #(
  parameter int N_CHANNELS  = 4,
  parameter int TIMER_WIDTH = 36,
  parameter int FIFO_DEPTH  = 8,
  parameter int EDGE_MODE   = 0,
  localparam int DATA_W     = TIMER_WIDTH + 2 + N_CHANNELS,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] channel,
  input  logic [N_CHANNELS-1:0] channel_mask,
  input  logic                  clear,
  input  logic                  operate,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     data,
  output logic [LVL_W-1:0]      fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [TIMER_WIDTH-1:0] timer;
  logic [N_CHANNELS-1:0]  channel_q;
  logic [N_CHANNELS-1:0]  hit;
  logic                   lost;
  logic                   wrap;
  logic                   gen;
  logic                   rd;
  logic                   wr;
  logic                   load;
  logic [DATA_W-1:0]      record;

  // Storage behind the output register. Total occupancy is mem_cnt plus the
  // output register, so a record written at edge E reaches the output at E+1.
  logic [DATA_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LVL_W-1:0]       mem_cnt;
  logic [DATA_W-1:0]      head;
  logic                   head_valid;

  // NOTE: every signal driven here gets a value on every path, so no latch.
  always_comb begin
    hit = channel & channel_mask;
    if (EDGE_MODE != 0) begin
      hit = channel & ~channel_q & channel_mask;
    end
    wrap       = (timer == '0);
    gen        = (|hit) || (wrap && operate);
    rd         = head_valid && out_ready;
    fifo_level = mem_cnt + LVL_W'(head_valid);
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    wr         = gen && ((fifo_level < LVL_W'(FIFO_DEPTH)) || rd);
    record     = {hit, lost, wrap, timer};
    // Refill the output register whenever it is empty or being consumed.
    load       = (mem_cnt != '0) && (!head_valid || rd);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= '0;
      channel_q  <= '0;
      lost       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_cnt    <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      timer     <= clear ? '0 : timer + TIMER_WIDTH'(1);
      channel_q <= channel;

      // The stored record already carries the sticky flag, so clear it there.
      if (wr) begin
        lost <= 1'b0;
      end else if (gen) begin
        lost <= 1'b1;
      end

      wr_ptr  <= wr_ptr + PTR_W'(wr);
      rd_ptr  <= rd_ptr + PTR_W'(load);
      mem_cnt <= mem_cnt + LVL_W'(wr) - LVL_W'(load);

      if (load) begin
        head       <= mem[rd_ptr];
        head_valid <= 1'b1;
      end else if (rd) begin
        head       <= '0;
        head_valid <= 1'b0;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and this keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= record;
    end
  end

  assign out_valid = head_valid;
  assign data      = head;

endmodule

// File: tb/tb_multi_click_stamper.sv
// -----------------------------------------------------------------------------
// tb_multi_click_stamper
//
// Drives two instances (level mode and rising-edge mode, 8-bit timer, depth 8)
// from shared stimulus and compares both against a queue-based reference model
// every cycle: directed scenarios first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_multi_click_stamper;

  localparam int NC = 4;
  localparam int TW = 8;
  localparam int FD = 8;
  localparam int DW = TW + 2 + NC;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] channel;
  logic [NC-1:0] channel_mask;
  logic          clear;
  logic          operate;
  logic          out_ready;

  logic          ov0, ov1;
  logic [DW-1:0] data0, data1;
  logic [LW-1:0] lvl0, lvl1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_click_stamper #(.N_CHANNELS(NC), .TIMER_WIDTH(TW), .FIFO_DEPTH(FD), .EDGE_MODE(0)) dut_level (
    .clk(clk), .reset(reset), .channel(channel), .channel_mask(channel_mask),
    .clear(clear), .operate(operate), .out_ready(out_ready),
    .out_valid(ov0), .data(data0), .fifo_level(lvl0)
  );

  multi_click_stamper #(.N_CHANNELS(NC), .TIMER_WIDTH(TW), .FIFO_DEPTH(FD), .EDGE_MODE(1)) dut_edge (
    .clk(clk), .reset(reset), .channel(channel), .channel_mask(channel_mask),
    .clear(clear), .operate(operate), .out_ready(out_ready),
    .out_valid(ov1), .data(data1), .fifo_level(lvl1)
  );

  // Reference model: a queue of records, each tagged with the first edge after
  // which it may be presented (one edge after it was stored). Index 0 models
  // level mode, index 1 rising-edge mode.
  typedef struct {
    logic [DW-1:0] rec;
    int            avail;
  } mrec_t;

  mrec_t      mq [2][$];
  int         m_timer [2];
  logic [3:0] m_chq [2];
  bit         m_lost [2];
  int         ecount = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_valid(input int k);
    return (mq[k].size() > 0) && (mq[k][0].avail <= ecount);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int k);
    return exp_valid(k) ? mq[k][0].rec : '0;
  endfunction

  task automatic model_step(input int k);
    logic [NC-1:0] hit;
    bit            wrap, gen, rd, wr;
    int            sz;
    mrec_t         e;
    if (reset) begin
      mq[k].delete();
      m_timer[k] = 0;
      m_lost[k]  = 1'b0;
      m_chq[k]   = '0;
      return;
    end
    hit  = (k == 1) ? (channel & ~m_chq[k] & channel_mask) : (channel & channel_mask);
    wrap = (m_timer[k] == 0);
    gen  = (hit != 0) || (wrap && operate);
    rd   = exp_valid(k) && out_ready;
    sz   = mq[k].size();
    if (rd) void'(mq[k].pop_front());
    wr = gen && ((sz < FD) || rd);
    if (wr) begin
      e.rec   = {hit, m_lost[k], wrap, 8'(m_timer[k])};
      e.avail = ecount + 2;
      mq[k].push_back(e);
      m_lost[k] = 1'b0;
    end else if (gen) begin
      m_lost[k] = 1'b1;
    end
    m_timer[k] = clear ? 0 : (m_timer[k] + 1) % (1 << TW);
    m_chq[k]   = channel;
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    ecount++;
    @(negedge clk);
    check("valid_lvl", ov0, exp_valid(0));
    check("data_lvl",  data0, exp_data(0));
    check("level_lvl", lvl0, mq[0].size());
    check("valid_edg", ov1, exp_valid(1));
    check("data_edg",  data1, exp_data(1));
    check("level_edg", lvl1, mq[1].size());
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Advance until the next edge will see the given timer value (bounded).
  task automatic wait_timer(input int t);
    int guard = 0;
    while (m_timer[0] != t && guard < 600) begin
      cycle();
      guard++;
    end
    check("wait_timer", m_timer[0], t);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      channel = 4'b0001;
      cycle();
      channel = '0;
      cycle();
    end
  endtask

  initial begin
    reset        = 1'b1;
    channel      = '0;
    channel_mask = '1;
    clear        = 1'b0;
    operate      = 1'b0;
    out_ready    = 1'b1;

    // Reset state.
    run(3);
    check("rst_valid", ov0, 0);
    check("rst_data",  data0, 0);
    check("rst_level", lvl0, 0);
    reset = 1'b0;

    // Single hit at timer 100: visible one edge later for exactly one cycle.
    wait_timer(100);
    channel = 4'b0010;
    cycle();
    check("single_early", ov0, 0);
    channel = '0;
    cycle();
    check("single_valid", ov0, 1);
    check("single_data",  data0, {4'b0010, 1'b0, 1'b0, 8'd100});
    cycle();
    check("single_once",  ov0, 0);
    run(3);

    // Level versus edge with a held input, then with the channel masked off.
    channel = 4'b0001;
    run(5);
    channel = '0;
    run(10);
    channel_mask = 4'b1110;
    channel = 4'b0001;
    run(5);
    channel = '0;
    channel_mask = '1;
    run(5);

    // Wrap marker coinciding with a hit, then free-running wraps.
    operate = 1'b1;
    wait_timer(0);
    channel = 4'b0010;
    cycle();
    channel = '0;
    run(600);
    operate = 1'b0;

    // Backpressure and overflow: 10 hits into a depth-8 FIFO.
    out_ready = 1'b0;
    pulses(10);
    check("ovf_level_lvl", lvl0, 8);
    check("ovf_level_edg", lvl1, 8);
    out_ready = 1'b1;
    channel = 4'b0001;
    cycle();
    channel = '0;
    run(15);

    // Full FIFO with simultaneous read and write.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    out_ready = 1'b0;
    pulses(8);
    check("full_level", lvl0, 8);
    out_ready = 1'b1;
    channel = 4'b0100;
    cycle();
    check("full_rw_level", lvl0, 8);
    channel = '0;
    run(12);

    // Reset in the middle of a queued stream.
    out_ready = 1'b0;
    pulses(5);
    reset = 1'b1;
    cycle();
    check("midrst_valid", ov0, 0);
    check("midrst_level", lvl0, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    run(10);

    // Clear coinciding with an event.
    channel = 4'b1000;
    clear   = 1'b1;
    cycle();
    channel = '0;
    clear   = 1'b0;
    run(5);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      clear        = ($urandom_range(0, 63) == 0);
      channel      = NC'($urandom);
      channel_mask = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '1;
      operate      = ($urandom_range(0, 1) == 1);
      out_ready    = ($urandom_range(0, 3) != 0) ^ (i[9] & i[8]);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
